// File: rtl/sram_axi_lite_slave.sv
// Purpose : AXI4-Lite responder in front of a word-addressed, byte-writable on-chip array.
// Latency : AR handshake -> RVALID after 1+RD_LAT cycles; later of AW/W -> BVALID after 1+WR_LAT cycles.
// Backpr. : one outstanding read and one outstanding write; R/B held stable until rready_i/bready_i.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-low reset
//   araddr_i/arvalid_i/arready_o  read address channel
//   rdata_o/rresp_o/rvalid_o/rready_i   read data channel (OKAY / DECERR)
//   awaddr_i/awvalid_i/awready_o  write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o   write data channel
//   bresp_o/bvalid_o/bready_i     write response channel (OKAY / DECERR)

module sram_axi_lite_slave #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h8000_0000,
    parameter int unsigned        DEPTH     = 4096,
    parameter int unsigned        RD_LAT    = 1,
    parameter int unsigned        WR_LAT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              rready_i,

    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Byte span of the array, one bit wider than the address so that a
    // window reaching the top of the address space still compares correctly.
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(64'(DEPTH) * 64'd4);

    localparam logic [3:0] RD_CNT = 4'(RD_LAT);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // ------------------------------------------------------------------
    // Storage. Not reset: contents survive a reset of the protocol logic.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Address decode. The offset is taken modulo 2^ADDR_W; the explicit
    // lower-bound compare rejects addresses below BASE_ADDR that would
    // otherwise wrap into a small offset.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] ar_off;
    logic [ADDR_W-1:0] aw_off;
    logic              ar_hit;
    logic              aw_hit;

    always_comb begin
        ar_off = araddr_i - BASE_ADDR;
        aw_off = awaddr_i - BASE_ADDR;
        ar_hit = (araddr_i >= BASE_ADDR) && ({1'b0, ar_off} < SPAN);
        aw_hit = (awaddr_i >= BASE_ADDR) && ({1'b0, aw_off} < SPAN);
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t         r_state;
    logic [3:0]        r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_hit;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_hit     <= 1'b0;
            arready_o <= 1'b1;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            rresp_o   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    // arready_o is high throughout R_IDLE, so arvalid_i alone
                    // marks the handshake.
                    if (arvalid_i) begin
                        r_idx     <= ar_off[IDX_W+1:2];
                        r_hit     <= ar_hit;
                        r_cnt     <= RD_CNT;
                        arready_o <= 1'b0;
                        r_state   <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        // Sampled on the same edge a write may commit, so a
                        // colliding read sees the pre-write word.
                        rdata_o  <= r_hit ? mem[r_idx] : '0;
                        rresp_o  <= r_hit ? RESP_OKAY : RESP_DECERR;
                        rvalid_o <= 1'b1;
                        r_state  <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rready_i) begin
                        rvalid_o  <= 1'b0;
                        arready_o <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: begin
                    arready_o <= 1'b1;
                    rvalid_o  <= 1'b0;
                    r_state   <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t         w_state;
    logic [3:0]        w_cnt;
    logic              aw_cap;
    logic              w_cap;
    logic [IDX_W-1:0]  w_idx;
    logic              w_hit;
    logic [DATA_W-1:0] w_dat;
    logic [3:0]        w_strb;

    logic              aw_take;
    logic              w_take;
    logic              commit;

    always_comb begin
        aw_take = (w_state == W_IDLE) && awvalid_i && awready_o;
        w_take  = (w_state == W_IDLE) && wvalid_i  && wready_o;
        // Reset wins over a commit that would fall on the same edge.
        commit  = rst_i && (w_state == W_WAIT) && (w_cnt == 4'd0) && w_hit;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            aw_cap    <= 1'b0;
            w_cap     <= 1'b0;
            w_idx     <= '0;
            w_hit     <= 1'b0;
            w_dat     <= '0;
            w_strb    <= '0;
            awready_o <= 1'b1;
            wready_o  <= 1'b1;
            bvalid_o  <= 1'b0;
            bresp_o   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_take) begin
                        w_idx     <= aw_off[IDX_W+1:2];
                        w_hit     <= aw_hit;
                        aw_cap    <= 1'b1;
                        awready_o <= 1'b0;
                    end
                    if (w_take) begin
                        w_dat    <= wdata_i;
                        w_strb   <= wstrb_i;
                        w_cap    <= 1'b1;
                        wready_o <= 1'b0;
                    end
                    // Both halves present, counting this cycle's captures.
                    if ((aw_cap || aw_take) && (w_cap || w_take)) begin
                        w_cnt   <= WR_CNT;
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 4'd0) begin
                        bresp_o  <= w_hit ? RESP_OKAY : RESP_DECERR;
                        bvalid_o <= 1'b1;
                        w_state  <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_o  <= 1'b0;
                        aw_cap    <= 1'b0;
                        w_cap     <= 1'b0;
                        awready_o <= 1'b1;
                        wready_o  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: begin
                    aw_cap    <= 1'b0;
                    w_cap     <= 1'b0;
                    awready_o <= 1'b1;
                    wready_o  <= 1'b1;
                    bvalid_o  <= 1'b0;
                    w_state   <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-masked commit; a zero strobe leaves the word untouched.
    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/sram_axi_lite_slave.md
# sram_axi_lite_slave

- AXI4-Lite responder (slave) fronting a word-addressed on-chip memory array.
- Terminates the read channel that the fetch unit drives, and also services the write channels used by the LSU.
- Read and write paths are independent state machines with programmable response latency.
- Out-of-range accesses return DECERR.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; WSTRB is 4 bits)
- BASE_ADDR, 32'h8000_0000, first byte address mapped to the array
- DEPTH, 4096, number of 32-bit words
- RD_LAT, 1, extra cycles between AR handshake and RVALID (0..15)
- WR_LAT, 1, extra cycles between AW+W capture and BVALID (0..15)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- araddr_i  in  ADDR_W  read address
- arvalid_i  in  1  read address valid
- arready_o  out  1  read address ready
- rdata_o  out  DATA_W  read data
- rresp_o  out  2  read response (2'b00 OKAY, 2'b11 DECERR)
- rvalid_o  out  1  read data valid
- rready_i  in  1  read data ready
- awaddr_i  in  ADDR_W  write address
- awvalid_i  in  1  write address valid
- awready_o  out  1  write address ready
- wdata_i  in  DATA_W  write data
- wstrb_i  in  4  byte enables
- wvalid_i  in  1  write data valid
- wready_o  out  1  write data ready
- bresp_o  out  2  write response
- bvalid_o  out  1  write response valid
- bready_i  in  1  write response ready

## Operation
Address decode:
- Word index = (addr − BASE_ADDR) >> 2; addr[1:0] ignored.
- In range iff BASE_ADDR ≤ addr < BASE_ADDR + 4·DEPTH; unsigned compare in ADDR_W bits.

Read FSM:
- R_IDLE: arready_o=1. On arvalid_i, latch address and in-range flag, load counter with RD_LAT, go to R_WAIT.
- R_WAIT: arready_o=0. Decrement counter. At 0, sample the array (or 0 if out of range), set rresp, go to R_RESP.
  - When RD_LAT=0, R_WAIT lasts one cycle.
- R_RESP: rvalid_o=1. rdata_o and rresp_o are held stable until rready_i, then return to R_IDLE.

Write FSM:
- W_IDLE: awready_o = !aw_captured; wready_o = !w_captured.
  - AW and W are captured independently, in either order or in the same cycle.
  - When both are captured, load counter with WR_LAT and go to W_WAIT.
- W_WAIT: both readies are 0. Count down. At 0, commit to the array, then go to W_RESP.
  - Commit writes bytes whose wstrb bit is set, only if in range.
  - bresp = OKAY, or DECERR if out of range.
- W_RESP: bvalid_o=1 until bready_i; then clear capture flags and return to W_IDLE.

Boundary rules:
- Same-cycle read sample and write commit to the same word: read returns the old data (read-before-write).
- wstrb=4'b0000: no bytes change; response is OKAY.
- Out-of-range write never modifies the array.
- Reset asserted mid-transaction: all pending transactions are dropped.
  - Outputs return to reset values on the next clock edge.
  - Array contents are retained; the array is not reset.

## Timing
Reset values:
- arready_o=1, awready_o=1, wready_o=1
- rvalid_o=0, bvalid_o=0
- rdata_o=0, rresp_o=0, bresp_o=0

Read latency:
- AR handshake at edge T → rvalid_o high from cycle T+1+RD_LAT.
- Next AR is accepted the cycle after the R handshake. No read pipelining: one outstanding read.

Write latency:
- Later of the AW/W handshakes at edge T → bvalid_o high from cycle T+1+WR_LAT.
- One outstanding write.

Concurrency and stability:
- Read and write paths operate concurrently with no mutual stalls.
- Handshakes use registered readies; no combinational path from any valid/ready input to any output.
- Outputs are stable while valid is asserted and ready is low.

## Test plan
1. **Write/read OKAY**
   - Stimulus: reset; write 0xDEADBEEF to 0x8000_0010 with wstrb=4'hF, AW and W in the same cycle; then read 0x8000_0010.
   - Response: bresp=00; rdata=0xDEADBEEF; rresp=00; rvalid exactly 2 cycles after AR (RD_LAT=1).
2. **Byte strobes and independent AW/W**
   - Stimulus: write 0x11223344 to 0x8000_0010 with wstrb=4'b0101 over 0xDEADBEEF; W issued 3 cycles before AW.
   - Response: read returns 0xDE22BE44; bvalid 2 cycles after AW.
3. **Out of range**
   - Stimulus: write 0x12345678 to 0x7FFF_FFFC and to 0x8000_4000 (DEPTH=4096); then read both.
   - Response: bresp=11 and rresp=11; rdata=0; no array word changed.
4. **Backpressure**
   - Stimulus: hold rready_i=0 and bready_i=0 for 5 cycles.
   - Response: rvalid/rdata/rresp and bvalid/bresp stay constant; arready/awready/wready stay 0; drop to R_IDLE/W_IDLE one cycle after ready.
5. **Collision**
   - Stimulus: with RD_LAT=WR_LAT=0, issue AR and AW/W to the same word in the same cycle, old value 0xA5A5A5A5, new value 0x5A5A5A5A.
   - Response: read returns 0xA5A5A5A5; a subsequent read returns 0x5A5A5A5A.
6. **Reset mid-flight**
   - Stimulus: assert rst_i=0 during R_WAIT and W_WAIT.
   - Response: next cycle rvalid=bvalid=0 and all readies=1; a previously written word still reads back intact.
